angle_calc: RTL and testbench

ANGLE_CALC -- requirements
Module: angle_calc

---
 rtl/herzel_pkg.sv | 26 ++
 rtl/angle_div.sv | 62 ++++++
 rtl/angle_calc.sv | 150 +++++++++++++++
 tb/tb_angle_calc.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/herzel_pkg.sv
// Shared definitions for the angle calculator: controller states and divider
// iteration/timing constants.
// Build option: ANGLE_CALC_ROUND_EN selects round-to-nearest (33 quotient bits).
package herzel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    STORE,
    DONE
  } state_t;

`ifdef ANGLE_CALC_ROUND_EN
  localparam int unsigned DIV_ITER = 33;
`else
  localparam int unsigned DIV_ITER = 32;
`endif

  // One LOAD cycle, DIV_ITER divide cycles and one STORE cycle per channel.
  localparam int unsigned CH_CYC = DIV_ITER + 2;

  // Width of the divider's iteration counter (holds 0..DIV_ITER-1).
  localparam int unsigned CNT_W = 6;

endpackage

// File: rtl/angle_div.sv
// Single-channel serial restoring divider, one quotient bit per cycle.
// Build option: ANGLE_CALC_ROUND_EN (via herzel_pkg) adds one extra fraction bit.
module angle_div
  import herzel_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [63:0]         dividend,
  input  logic [31:0]         divisor,
  output logic [DIV_ITER-1:0] quotient,
  output logic                done
);

  logic [31:0]         rem_q;
  logic [31:0]         rem_d;
  logic [31:0]         lo_q;
  logic [DIV_ITER-1:0] q_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic [32:0]         trial;
  logic                qbit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial = {rem_q, lo_q[31]};
    qbit  = (trial >= {1'b0, divisor});
    rem_d = qbit ? (trial[31:0] - divisor) : trial[31:0];
  end

  assign done     = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
  assign quotient = q_q;

  // Iteration state. The caller guarantees dividend[63:32] < divisor whenever
  // the result is used, so the upper quotient half is zero and the partial
  // remainder is seeded directly with dividend[63:32]; only the low half (plus
  // zero fill for a rounding bit) is iterated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q  <= '0;
      lo_q   <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= dividend[63:32];
      lo_q   <= dividend[31:0];
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      lo_q  <= {lo_q[30:0], 1'b0};
      q_q   <= {q_q[DIV_ITER-2:0], qbit};
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/angle_calc.sv
// Per-channel normalised phase step: angle[i] = freq[i] * 2^32 / samp_freq,
// computed channel by channel with a shared serial divider.
// Build option: ANGLE_CALC_ROUND_EN rounds to nearest instead of truncating.
module angle_calc
  import herzel_pkg::*;
#(
  parameter int unsigned NF = 11
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en_i,
  input  logic                 reset_h_i,
  input  logic [NF-1:0][31:0]  freq_arr_i,
  input  logic [31:0]          samp_freq_i,
  output logic [NF-1:0][31:0]  angle_arr_o,
  output logic                 valid_angel_o,
  output logic                 busy_o,
  output logic [NF-1:0]        err_o
);

  localparam int unsigned CH_W = (NF > 1) ? $clog2(NF) : 1;

  state_t              state_q;
  logic                en_s_q;
  logic                en_h_q;
  logic                start_edge;
  logic [CH_W-1:0]     ch_q;
  logic [NF-1:0][31:0] freq_s_q;
  logic [31:0]         samp_s_q;
  logic [NF-1:0][31:0] angle_q;
  logic [NF-1:0]       err_q;
  logic                valid_q;
  logic                busy_q;

  logic [31:0]         cur_f;
  logic                div_start;
  logic [DIV_ITER-1:0] quot;
  logic                div_done;
  logic                ch_err;
  logic [31:0]         res;
`ifdef ANGLE_CALC_ROUND_EN
  logic [32:0]         rounded;
`endif

  assign start_edge  = en_s_q & ~en_h_q;
  assign cur_f       = freq_s_q[ch_q];
  assign div_start   = (state_q == LOAD);

  assign angle_arr_o   = angle_q;
  assign err_o         = err_q;
  assign valid_angel_o = valid_q;
  assign busy_o        = busy_q;

  angle_div u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .dividend ({cur_f, 32'h0}),
    .divisor  (samp_s_q),
    .quotient (quot),
    .done     (div_done)
  );

  // Channel result: saturate on range error, otherwise the (rounded) quotient.
  always_comb begin
    ch_err = (samp_s_q == '0) || (cur_f >= samp_s_q);
`ifdef ANGLE_CALC_ROUND_EN
    rounded = {1'b0, quot[32:1]} + {32'b0, quot[0]};
    res     = rounded[32] ? '1 : rounded[31:0];
`else
    res     = quot;
`endif
    if (ch_err) begin
      res = '1;
    end
  end

  // en_i is registered once (en_s_q); en_h_q is its history for edge detect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_s_q <= 1'b0;
      en_h_q <= 1'b0;
    end else begin
      en_s_q <= en_i;
      en_h_q <= en_s_q;
    end
  end

  // Controller: snapshot inputs on start, sequence channels, register outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      freq_s_q <= '0;
      samp_s_q <= '0;
      angle_q  <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (reset_h_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      angle_q <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q  <= LOAD;
            freq_s_q <= freq_arr_i;
            samp_s_q <= samp_freq_i;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= DIV;
        end
        DIV: begin
          if (div_done) begin
            state_q <= STORE;
          end
        end
        STORE: begin
          angle_q[ch_q] <= res;
          err_q[ch_q]   <= ch_err;
          if (ch_q == CH_W'(NF - 1)) begin
            state_q <= DONE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= LOAD;
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_angle_calc.sv
// Self-checking bench for angle_calc (scoreboard of expected angle sets).
// Build option: ANGLE_CALC_ROUND_EN selects the rounding reference model.
module tb_angle_calc;

  localparam int NF = 11;
`ifdef ANGLE_CALC_ROUND_EN
  localparam int CYC = 35;
  localparam logic [31:0] THIRD2 = 32'hAAAA_AAAB;
`else
  localparam int CYC = 34;
  localparam logic [31:0] THIRD2 = 32'hAAAA_AAAA;
`endif
  localparam int EXP_VALID = NF * CYC + 2;
  localparam int LIMIT     = 2000;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                en_i = 1'b0;
  logic                reset_h_i = 1'b0;
  logic [NF-1:0][31:0] freq_arr_i = '0;
  logic [31:0]         samp_freq_i = '0;
  logic [NF-1:0][31:0] angle_arr_o;
  logic                valid_angel_o;
  logic                busy_o;
  logic [NF-1:0]       err_o;

  typedef struct packed {
    logic [NF-1:0][31:0] a;
    logic [NF-1:0]       e;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  angle_calc #(.NF(NF)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en_i          (en_i),
    .reset_h_i     (reset_h_i),
    .freq_arr_i    (freq_arr_i),
    .samp_freq_i   (samp_freq_i),
    .angle_arr_o   (angle_arr_o),
    .valid_angel_o (valid_angel_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  // Reference: floor(f*2^32/s), or round-to-nearest of f*2^33/s when enabled.
  function automatic void model(input logic [31:0] f, input logic [31:0] s,
                                output logic [31:0] a, output logic e);
    logic [95:0] num;
    logic [95:0] q;
    if (s == 0 || f >= s) begin
      a = '1;
      e = 1'b1;
    end else begin
      e = 1'b0;
`ifdef ANGLE_CALC_ROUND_EN
      num = {31'b0, f, 33'b0};
      q   = num / {64'b0, s};
      q   = (q >> 1) + (q & 96'd1);
      a   = (q > 96'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
`else
      num = {32'b0, f, 32'b0};
      q   = num / {64'b0, s};
      a   = q[31:0];
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Pulse en_i for one cycle; cyc = 0 at the edge that samples it high.
  task automatic start_run(input bit push);
    exp_t x;
    logic [31:0] a;
    logic e;
    if (push) begin
      for (int i = 0; i < NF; i++) begin
        model(freq_arr_i[i], samp_freq_i, a, e);
        x.a[i] = a;
        x.e[i] = e;
      end
      sb.push_back(x);
    end
    en_i = 1'b1;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    en_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output bit gap);
    ok  = 1'b0;
    gap = 1'b0;
    while (cyc < LIMIT) begin
      step();
      if (valid_angel_o) begin
        ok = 1'b1;
        break;
      end
      if (!busy_o) gap = 1'b1;
    end
  endtask

  task automatic rand_freqs(input int unsigned hi);
    for (int i = 0; i < NF; i++) freq_arr_i[i] = $urandom_range(0, hi);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #23;
    total++;
    if (angle_arr_o !== '0 || err_o !== '0 || valid_angel_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL reset_outputs: angles=%h err=%h valid=%b busy=%b, required all zero",
               angle_arr_o, err_o, valid_angel_o, busy_o);
    end else passed++;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok, gap;
    exp_t x;
    samp_freq_i = 32'd200000;
    rand_freqs(199999);
    freq_arr_i[0] = 32'd50000;
    freq_arr_i[1] = 32'd100000;
    freq_arr_i[2] = 32'd0;
    start_run(1);
    step();
    total++;
    if (valid_angel_o !== 1'b0 || busy_o !== 1'b1) begin
      $display("FAIL basic_start: valid=%b busy=%b, required valid=0 busy=1", valid_angel_o, busy_o);
    end else passed++;
    wait_valid(ok, gap);
    total++;
    if (!ok || cyc !== EXP_VALID) begin
      $display("FAIL basic_valid_cycle: ok=%b cycle=%0d, required %0d", ok, cyc, EXP_VALID);
    end else passed++;
    total++;
    if (gap) $display("FAIL basic_busy: busy gap=1, required 0"); else passed++;
    x = sb.pop_front();
    last_exp = x;
    for (int i = 0; i < NF; i++) begin
      total++;
      if (angle_arr_o[i] !== x.a[i]) begin
        $display("FAIL basic_angle[%0d]: got %h, required %h", i, angle_arr_o[i], x.a[i]);
      end else passed++;
    end
    total++;
    if (angle_arr_o[0] !== 32'h4000_0000 || angle_arr_o[1] !== 32'h8000_0000 ||
        angle_arr_o[2] !== 32'h0 || err_o !== '0) begin
      $display("FAIL basic_literals: a0=%h a1=%h a2=%h err=%h, required 40000000 80000000 0 0",
               angle_arr_o[0], angle_arr_o[1], angle_arr_o[2], err_o);
    end else passed++;
  endtask

  task automatic test_errors();
    bit ok, gap;
    exp_t x;
    samp_freq_i = 32'd200000;
    rand_freqs(199999);
    freq_arr_i[3] = 32'd200000;
    start_run(1);
    wait_valid(ok, gap);
    x = sb.pop_front();
    last_exp = x;
    total++;
    if (!ok || angle_arr_o !== x.a || err_o !== x.e) begin
      $display("FAIL err_ch3_all: ok=%b err=%h, required err=%h", ok, err_o, x.e);
    end else passed++;
    total++;
    if (angle_arr_o[3] !== 32'hFFFF_FFFF || err_o !== NF'(1 << 3)) begin
      $display("FAIL err_ch3: a3=%h err=%h, required ffffffff %h", angle_arr_o[3], err_o, NF'(1 << 3));
    end else passed++;
    samp_freq_i = 32'd0;
    rand_freqs(1000);
    start_run(1);
    wait_valid(ok, gap);
    x = sb.pop_front();
    last_exp = x;
    total++;
    if (!ok || cyc !== EXP_VALID || angle_arr_o !== x.a || angle_arr_o !== {NF{32'hFFFF_FFFF}} ||
        err_o !== {NF{1'b1}}) begin
      $display("FAIL err_samp0: ok=%b cycle=%0d err=%h a0=%h, required cycle %0d err all ones",
               ok, cyc, err_o, angle_arr_o[0], EXP_VALID);
    end else passed++;
  endtask

  task automatic test_thirds();
    bit ok, gap;
    exp_t x;
    samp_freq_i = 32'd3;
    freq_arr_i = '0;
    freq_arr_i[0] = 32'd2;
    freq_arr_i[1] = 32'd1;
    start_run(1);
    wait_valid(ok, gap);
    x = sb.pop_front();
    last_exp = x;
    total++;
    if (!ok || cyc !== EXP_VALID) begin
      $display("FAIL thirds_cycle: ok=%b cycle=%0d, required %0d", ok, cyc, EXP_VALID);
    end else passed++;
    total++;
    if (angle_arr_o[0] !== THIRD2 || angle_arr_o !== x.a || err_o !== '0) begin
      $display("FAIL thirds_value: a0=%h a1=%h err=%h, required a0=%h a1=%h", angle_arr_o[0],
               angle_arr_o[1], err_o, THIRD2, x.a[1]);
    end else passed++;
  endtask

  task automatic test_snapshot();
    bit ok, gap;
    bit early_gap;
    exp_t x;
    samp_freq_i = 32'd1000000;
    rand_freqs(999999);
    start_run(1);
    early_gap = 1'b0;
    while (cyc < 100) begin
      step();
      if (!busy_o) early_gap = 1'b1;
    end
    x = sb[0];
    total++;
    if (angle_arr_o[0] !== x.a[0]) begin
      $display("FAIL snap_ch0_stored: got %h, required %h", angle_arr_o[0], x.a[0]);
    end else passed++;
    for (int i = 2; i < NF; i++) begin
      total++;
      if (angle_arr_o[i] !== last_exp.a[i]) begin
        $display("FAIL snap_hold[%0d]: got %h, required %h", i, angle_arr_o[i], last_exp.a[i]);
      end else passed++;
    end
    freq_arr_i[0] = 32'd12345;
    freq_arr_i[5] = 32'd0;
    samp_freq_i   = 32'd7;
    en_i = 1'b1;
    step();
    en_i = 1'b0;
    wait_valid(ok, gap);
    x = sb.pop_front();
    last_exp = x;
    total++;
    if (!ok || cyc !== EXP_VALID || gap || early_gap) begin
      $display("FAIL snap_timing: ok=%b cycle=%0d gap=%b/%b, required cycle %0d no gap",
               ok, cyc, early_gap, gap, EXP_VALID);
    end else passed++;
    total++;
    if (angle_arr_o !== x.a || err_o !== x.e) begin
      $display("FAIL snap_values: a0=%h a5=%h err=%h, required a0=%h a5=%h err=%h",
               angle_arr_o[0], angle_arr_o[5], err_o, x.a[0], x.a[5], x.e);
    end else passed++;
    repeat (5) step();
    total++;
    if (busy_o !== 1'b0 || valid_angel_o !== 1'b1) begin
      $display("FAIL snap_no_restart: busy=%b valid=%b, required busy=0 valid=1", busy_o, valid_angel_o);
    end else passed++;
  endtask

  task automatic test_soft_clear();
    bit ok, gap;
    exp_t x;
    samp_freq_i = 32'd48000;
    rand_freqs(47999);
    start_run(0);
    while (cyc < 199) step();
    reset_h_i = 1'b1;
    step();
    reset_h_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || valid_angel_o !== 1'b0 || angle_arr_o !== '0 || err_o !== '0) begin
      $display("FAIL clear_outputs: busy=%b valid=%b a0=%h err=%h, required all zero",
               busy_o, valid_angel_o, angle_arr_o[0], err_o);
    end else passed++;
    repeat (3) step();
    total++;
    if (busy_o !== 1'b0) $display("FAIL clear_idle: busy=%b, required 0", busy_o); else passed++;
    start_run(1);
    wait_valid(ok, gap);
    x = sb.pop_front();
    last_exp = x;
    total++;
    if (!ok || cyc !== EXP_VALID || angle_arr_o !== x.a || err_o !== x.e) begin
      $display("FAIL clear_rerun: ok=%b cycle=%0d a0=%h, required cycle %0d a0=%h",
               ok, cyc, angle_arr_o[0], EXP_VALID, x.a[0]);
    end else passed++;
  endtask

  task automatic test_clear_priority();
    bit seen;
    en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_i = 1'b0;
    reset_h_i = 1'b1;
    step();
    reset_h_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (busy_o) seen = 1'b1;
      step();
    end
    total++;
    if (seen || valid_angel_o !== 1'b0) begin
      $display("FAIL clear_priority: busy seen=%b valid=%b, required 0 0", seen, valid_angel_o);
    end else passed++;
  endtask

  task automatic test_rstn_abort();
    bit ok, gap;
    bit seen;
    exp_t x;
    samp_freq_i = 32'd192000;
    rand_freqs(191999);
    start_run(0);
    while (cyc < 50) step();
    rstn = 1'b0;
    #1;
    total++;
    if (angle_arr_o !== '0 || err_o !== '0 || valid_angel_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL rstn_abort: a0=%h err=%h valid=%b busy=%b, required all zero",
               angle_arr_o[0], err_o, valid_angel_o, busy_o);
    end else passed++;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (400) begin
      step();
      if (valid_angel_o || busy_o) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL rstn_no_valid: activity seen=1, required 0"); else passed++;
    start_run(1);
    wait_valid(ok, gap);
    x = sb.pop_front();
    last_exp = x;
    total++;
    if (!ok || cyc !== EXP_VALID || angle_arr_o !== x.a || err_o !== x.e) begin
      $display("FAIL rstn_rerun: ok=%b cycle=%0d a0=%h, required cycle %0d a0=%h",
               ok, cyc, angle_arr_o[0], EXP_VALID, x.a[0]);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok, gap;
    exp_t x;
    for (int r = 0; r < 2; r++) begin
      samp_freq_i = (r == 0) ? 32'hFFFF_FFFF : 32'd44100;
      rand_freqs((r == 0) ? 32'hFFFF_FFFE : 32'd50000);
      start_run(1);
      wait_valid(ok, gap);
      x = sb.pop_front();
      total++;
      if (!ok || cyc !== EXP_VALID || angle_arr_o !== x.a || err_o !== x.e) begin
        $display("FAIL b2b_run%0d: ok=%b cycle=%0d err=%h, required cycle %0d err=%h",
                 r, ok, cyc, err_o, EXP_VALID, x.e);
      end else passed++;
    end
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_thirds();
    test_snapshot();
    test_soft_clear();
    test_clear_priority();
    test_rstn_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
